// File: rtl/mdma_ram_ecc_pkg.sv
// Purpose: shared constants, types and SECDED(99,91) encoder for the
//          91-bit x 16-entry RAM responder.
// Contents:
//   DATA_W/CHK_W/CW_W/DEPTH   geometry
//   codeword_t                {par, ham[6:0], data[90:0]}; data sits at the
//                             codeword LSBs, so codeword bits 0/1 are data bits 0/1
//   dec_res_t                 decoder result {data, sbe, dbe}
//   POS_TAB                   Hamming position (1..98, non power of two) per data bit
//   ecc91_ham / ecc91_enc     check-bit generation and full encode
package mdma_ram_ecc_pkg;

  localparam int unsigned DATA_W = 91;
  localparam int unsigned HAM_W  = 7;
  localparam int unsigned CHK_W  = HAM_W + 1;
  localparam int unsigned CW_W   = DATA_W + CHK_W;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic              par;
    logic [HAM_W-1:0]  ham;
    logic [DATA_W-1:0] data;
  } codeword_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sbe;
    logic              dbe;
  } dec_res_t;

  // Data bits occupy the non-power-of-two Hamming positions 3..98 in order.
  function automatic logic [DATA_W*HAM_W-1:0] pos_tab();
    logic [DATA_W*HAM_W-1:0] t;
    int unsigned             n;
    t = '0;
    n = 0;
    for (int unsigned p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        t[n*HAM_W +: HAM_W] = HAM_W'(p);
        n++;
      end
    end
    return t;
  endfunction

  localparam logic [DATA_W*HAM_W-1:0] POS_TAB = pos_tab();

  // Hamming check bits: XOR of the positions of all set data bits.
  function automatic logic [HAM_W-1:0] ecc91_ham(input logic [DATA_W-1:0] d);
    logic [HAM_W-1:0] h;
    h = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (d[i]) h = h ^ POS_TAB[i*HAM_W +: HAM_W];
    end
    return h;
  endfunction

  // Full encode; overall parity makes the whole codeword even.
  function automatic codeword_t ecc91_enc(input logic [DATA_W-1:0] d);
    codeword_t cw;
    cw.data = d;
    cw.ham  = ecc91_ham(d);
    cw.par  = ^{cw.ham, d};
    return cw;
  endfunction

endpackage

// File: rtl/mdma_91bx16_91bwe_ram_if.sv
// Purpose: engine-side RAM port bundle (91-bit data, 16 entries).
// Signals:
//   wadr/wen/wdat   write address, enable, data   (master -> responder)
//   ren/radr        read enable, address          (master -> responder)
//   rdat/rsbe/rdbe  read data, single/double error flags (responder -> master)
interface mdma_91bx16_91bwe_ram_if;
  import mdma_ram_ecc_pkg::*;

  logic [ADDR_W-1:0] wadr;
  logic              wen;
  logic [DATA_W-1:0] wdat;
  logic              ren;
  logic [ADDR_W-1:0] radr;
  logic [DATA_W-1:0] rdat;
  logic              rsbe;
  logic              rdbe;

  modport s (input wadr, wen, wdat, ren, radr, output rdat, rsbe, rdbe);
  modport m (output wadr, wen, wdat, ren, radr, input rdat, rsbe, rdbe);

endinterface

// File: rtl/mdma_secded91_dec.sv
// Purpose: combinational SECDED(99,91) decoder.
// Ports:
//   cw_i     stored codeword
//   res_c_o  decoded data plus sbe/dbe classification (combinational)
// Single error: data corrected, sbe=1. Double (or uncorrectable) error:
// raw data bits passed through, dbe=1.
module mdma_secded91_dec
  import mdma_ram_ecc_pkg::*;
(
  input  codeword_t cw_i,
  output dec_res_t  res_c_o
);

  logic [HAM_W-1:0] syn_c;
  logic             ovr_c;

  always_comb begin
    syn_c         = cw_i.ham ^ ecc91_ham(cw_i.data);
    ovr_c         = ^cw_i;
    res_c_o.data  = cw_i.data;
    res_c_o.sbe   = 1'b0;
    res_c_o.dbe   = 1'b0;
    if (ovr_c) begin
      // Odd parity: one flipped bit, unless the syndrome points past the codeword.
      if (syn_c > HAM_W'(CW_W - 1)) begin
        res_c_o.dbe = 1'b1;
      end else begin
        res_c_o.sbe = 1'b1;
        for (int unsigned i = 0; i < DATA_W; i++) begin
          if (syn_c == POS_TAB[i*HAM_W +: HAM_W]) res_c_o.data[i] = ~cw_i.data[i];
        end
      end
    end else if (syn_c != '0) begin
      res_c_o.dbe = 1'b1;
    end
  end

endmodule

// File: rtl/mdma_91bx16_ram_resp.sv
// Purpose: responder end of the 91b x 16 RAM port: ECC-protected storage,
//          registered read data with SBE/DBE flags, error injection and
//          saturating error counters.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ram               slave modport (wadr/wen/wdat/ren/radr in, rdat/rsbe/rdbe out)
//   inj_sbe/inj_dbe   corrupt codeword bit 0 / bits 0,1 on the next write
//   sbe_cnt/dbe_cnt   saturating counts of reads reporting rsbe / rdbe
// Parameters: RD_LAT (1 or 2), INIT_ZERO (never-written entries read as 0).
module mdma_91bx16_ram_resp
  import mdma_ram_ecc_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  mdma_91bx16_91bwe_ram_if.s   ram,
  input  logic                 inj_sbe,
  input  logic                 inj_dbe,
  output logic [CNT_W-1:0]     sbe_cnt,
  output logic [CNT_W-1:0]     dbe_cnt
);

  logic [CW_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              pend_sbe_q, pend_sbe_d;
  logic              pend_dbe_q, pend_dbe_d;
  logic [CW_W-1:0]   wr_cw_c;

  // Fetch stage: codeword captured at the sampling edge (gives read-first).
  logic              f_vld_q, f_vld_d;
  logic              f_ent_q, f_ent_d;
  codeword_t         f_cw_q, f_cw_d;
  // Extra stage used only when RD_LAT == 2.
  logic              p_vld_q, p_vld_d;
  logic              p_ent_q, p_ent_d;
  codeword_t         p_cw_q, p_cw_d;

  codeword_t         dec_cw_c;
  logic              out_vld_c, out_ent_c;
  dec_res_t          dec_res_c;

  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rsbe_q, rsbe_d;
  logic              rdbe_q, rdbe_d;
  logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d;
  logic [CNT_W-1:0]  dbe_cnt_q, dbe_cnt_d;

  // Encode write data and apply a pending (or same-edge) injection; DBE wins.
  always_comb begin
    wr_cw_c = ecc91_enc(ram.wdat);
    if (pend_dbe_q || inj_dbe) begin
      wr_cw_c[1:0] = ~wr_cw_c[1:0];
    end else if (pend_sbe_q || inj_sbe) begin
      wr_cw_c[0] = ~wr_cw_c[0];
    end
  end

  // Valid vector and injection latches; a write consumes both pending requests.
  always_comb begin
    valid_d    = valid_q;
    pend_sbe_d = pend_sbe_q | inj_sbe;
    pend_dbe_d = pend_dbe_q | inj_dbe;
    if (ram.wen) begin
      valid_d[ram.wadr] = 1'b1;
      pend_sbe_d        = 1'b0;
      pend_dbe_d        = 1'b0;
    end
  end

  // Read pipeline next-state.
  always_comb begin
    f_vld_d = ram.ren;
    f_ent_d = valid_q[ram.radr];
    f_cw_d  = ram.ren ? codeword_t'(mem_q[ram.radr]) : f_cw_q;
    p_vld_d = f_vld_q;
    p_ent_d = f_ent_q;
    p_cw_d  = f_vld_q ? f_cw_q : p_cw_q;
  end

  // Decoder input comes from the last pipeline stage for the chosen latency.
  always_comb begin
    dec_cw_c  = (RD_LAT == 2) ? p_cw_q  : f_cw_q;
    out_vld_c = (RD_LAT == 2) ? p_vld_q : f_vld_q;
    out_ent_c = (RD_LAT == 2) ? p_ent_q : f_ent_q;
  end

  mdma_secded91_dec u_dec (
    .cw_i    (dec_cw_c),
    .res_c_o (dec_res_c)
  );

  // Output registers hold until the next result; counters saturate.
  always_comb begin
    rdat_d    = rdat_q;
    rsbe_d    = rsbe_q;
    rdbe_d    = rdbe_q;
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (out_vld_c) begin
      if (INIT_ZERO && !out_ent_c) begin
        rdat_d = '0;
        rsbe_d = 1'b0;
        rdbe_d = 1'b0;
      end else begin
        rdat_d = dec_res_c.data;
        rsbe_d = dec_res_c.sbe;
        rdbe_d = dec_res_c.dbe;
      end
      if (rsbe_d && (sbe_cnt_q != '1)) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
      if (rdbe_d && (dbe_cnt_q != '1)) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram.wen) mem_q[ram.wadr] <= wr_cw_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      pend_sbe_q <= 1'b0;
      pend_dbe_q <= 1'b0;
      f_vld_q    <= 1'b0;
      f_ent_q    <= 1'b0;
      f_cw_q     <= '0;
      p_vld_q    <= 1'b0;
      p_ent_q    <= 1'b0;
      p_cw_q     <= '0;
      rdat_q     <= '0;
      rsbe_q     <= 1'b0;
      rdbe_q     <= 1'b0;
      sbe_cnt_q  <= '0;
      dbe_cnt_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      pend_sbe_q <= pend_sbe_d;
      pend_dbe_q <= pend_dbe_d;
      f_vld_q    <= f_vld_d;
      f_ent_q    <= f_ent_d;
      f_cw_q     <= f_cw_d;
      p_vld_q    <= p_vld_d;
      p_ent_q    <= p_ent_d;
      p_cw_q     <= p_cw_d;
      rdat_q     <= rdat_d;
      rsbe_q     <= rsbe_d;
      rdbe_q     <= rdbe_d;
      sbe_cnt_q  <= sbe_cnt_d;
      dbe_cnt_q  <= dbe_cnt_d;
    end
  end

  assign ram.rdat = rdat_q;
  assign ram.rsbe = rsbe_q;
  assign ram.rdbe = rdbe_q;
  assign sbe_cnt  = sbe_cnt_q;
  assign dbe_cnt  = dbe_cnt_q;

endmodule

// File: tb/tb_mdma_91bx16_ram_resp.sv
// Bench for mdma_91bx16_ram_resp: one RD_LAT=1 and one RD_LAT=2 instance share
// the same stimulus; an entry-level model predicts outputs and counters.
module tb_mdma_91bx16_ram_resp;
  import mdma_ram_ecc_pkg::*;

  localparam int unsigned OUT_W = DATA_W + 2 + 2*CNT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] wadr, radr;
  logic              wen, ren;
  logic [DATA_W-1:0] wdat;
  logic              inj_sbe, inj_dbe;
  logic [CNT_W-1:0]  sbe_cnt1, dbe_cnt1, sbe_cnt2, dbe_cnt2;

  mdma_91bx16_91bwe_ram_if ram1 ();
  mdma_91bx16_91bwe_ram_if ram2 ();

  assign ram1.wadr = wadr;  assign ram2.wadr = wadr;
  assign ram1.wen  = wen;   assign ram2.wen  = wen;
  assign ram1.wdat = wdat;  assign ram2.wdat = wdat;
  assign ram1.ren  = ren;   assign ram2.ren  = ren;
  assign ram1.radr = radr;  assign ram2.radr = radr;

  mdma_91bx16_ram_resp #(.RD_LAT(1), .INIT_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ram(ram1), .inj_sbe(inj_sbe), .inj_dbe(inj_dbe),
    .sbe_cnt(sbe_cnt1), .dbe_cnt(dbe_cnt1));

  mdma_91bx16_ram_resp #(.RD_LAT(2), .INIT_ZERO(1'b1)) dut2 (
    .clk(clk), .rst(rst), .ram(ram2), .inj_sbe(inj_sbe), .inj_dbe(inj_dbe),
    .sbe_cnt(sbe_cnt2), .dbe_cnt(dbe_cnt2));

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic cmp(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: per-entry data, validity and corruption kind ----
  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              s;
    logic              e;
  } res_t;

  logic [DATA_W-1:0] m_data  [DEPTH];
  int                m_kind  [DEPTH];   // 0 clean, 1 one bit flipped, 2 two bits flipped
  bit                m_valid [DEPTH];
  bit                m_ps, m_pd;
  res_t              m_nr, q1, q2a, q2b;
  logic [DATA_W-1:0] e_rdat [2];
  logic              e_rsbe [2];
  logic              e_rdbe [2];
  int                e_sc   [2];
  int                e_dc   [2];

  task automatic m_load(input int k, input res_t r);
    if (r.v) begin
      e_rdat[k] = r.d;
      e_rsbe[k] = r.s;
      e_rdbe[k] = r.e;
      if (r.s && e_sc[k] < 65535) e_sc[k]++;
      if (r.e && e_dc[k] < 65535) e_dc[k]++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        e_rdat[k] = '0; e_rsbe[k] = 1'b0; e_rdbe[k] = 1'b0; e_sc[k] = 0; e_dc[k] = 0;
      end
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      q1 = '0; q2a = '0; q2b = '0;
      m_ps = 1'b0; m_pd = 1'b0;
    end else begin
      m_nr   = '0;
      m_nr.v = ren;
      if (ren && m_valid[radr]) begin
        m_nr.d = m_data[radr];
        if (m_kind[radr] == 1) m_nr.s = 1'b1;
        if (m_kind[radr] == 2) begin
          m_nr.d = m_data[radr] ^ DATA_W'(3);
          m_nr.e = 1'b1;
        end
      end
      if (wen) begin
        m_kind[wadr]  = (m_pd || inj_dbe) ? 2 : ((m_ps || inj_sbe) ? 1 : 0);
        m_data[wadr]  = wdat;
        m_valid[wadr] = 1'b1;
        m_ps = 1'b0; m_pd = 1'b0;
      end else begin
        m_ps = m_ps | inj_sbe;
        m_pd = m_pd | inj_dbe;
      end
      m_load(0, q1);  q1 = m_nr;
      m_load(1, q2b); q2b = q2a; q2a = m_nr;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cyc dut1", {ram1.rdat, ram1.rsbe, ram1.rdbe, sbe_cnt1, dbe_cnt1},
          {e_rdat[0], e_rsbe[0], e_rdbe[0], CNT_W'(e_sc[0]), CNT_W'(e_dc[0])});
      cmp("cyc dut2", {ram2.rdat, ram2.rsbe, ram2.rdbe, sbe_cnt2, dbe_cnt2},
          {e_rdat[1], e_rsbe[1], e_rdbe[1], CNT_W'(e_sc[1]), CNT_W'(e_dc[1])});
    end
  end

  // ---------------- stimulus with literal expectations --------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wen = 1'b1; wadr = a; wdat = d;
    step();
    wen = 1'b0;
  endtask

  task automatic inj(input bit dbe);
    if (dbe) inj_dbe = 1'b1; else inj_sbe = 1'b1;
    step();
    inj_sbe = 1'b0; inj_dbe = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic s, input logic e);
    ren = 1'b1; radr = a;
    step();
    ren = 1'b0;
    step();
    cmp({name, " dut1"}, OUT_W'({ram1.rdat, ram1.rsbe, ram1.rdbe}), OUT_W'({d, s, e}));
    step();
    cmp({name, " dut2"}, OUT_W'({ram2.rdat, ram2.rsbe, ram2.rdbe}), OUT_W'({d, s, e}));
  endtask

  task automatic cnt_check(input string name, input int sc, input int dc);
    cmp({name, " cnt1"}, OUT_W'({sbe_cnt1, dbe_cnt1}), OUT_W'({CNT_W'(sc), CNT_W'(dc)}));
    cmp({name, " cnt2"}, OUT_W'({sbe_cnt2, dbe_cnt2}), OUT_W'({CNT_W'(sc), CNT_W'(dc)}));
  endtask

  logic [DATA_W-1:0] pat_a;
  logic [DATA_W-1:0] bb [DEPTH];

  initial begin
    rst = 1'b1;
    idle();
    wadr = '0; radr = '0; wdat = '0;
    pat_a = DATA_W'({12{8'hA5}});
    step(); step();
    chk_en = 1'b1;
    cmp("reset out1", OUT_W'({ram1.rdat, ram1.rsbe, ram1.rdbe}), '0);
    cmp("reset out2", OUT_W'({ram2.rdat, ram2.rsbe, ram2.rdbe}), '0);
    cnt_check("reset", 0, 0);
    rst = 1'b0;
    step();

    // Basic write then read on the next edge.
    wr(4'd3, pat_a);
    rd_check("basic", 4'd3, pat_a, 1'b0, 1'b0);

    // Single-bit injection, corrected on every read.
    inj(1'b0);
    wr(4'd7, DATA_W'(1));
    rd_check("sbe rd1", 4'd7, DATA_W'(1), 1'b1, 1'b0);
    cnt_check("sbe rd1", 1, 0);
    rd_check("sbe rd2", 4'd7, DATA_W'(1), 1'b1, 1'b0);
    cnt_check("sbe rd2", 2, 0);

    // The injection was consumed: next write is clean.
    wr(4'd8, DATA_W'(5));
    rd_check("consumed", 4'd8, DATA_W'(5), 1'b0, 1'b0);

    // Double-bit injection: raw data bits 0,1 flipped, DBE flag.
    inj(1'b1);
    wr(4'd15, '0);
    rd_check("dbe", 4'd15, DATA_W'(3), 1'b0, 1'b1);
    cnt_check("dbe", 2, 1);

    // Both pending: double wins.
    inj(1'b0);
    inj(1'b1);
    wr(4'd14, DATA_W'(16));
    rd_check("both", 4'd14, DATA_W'(19), 1'b0, 1'b1);
    cnt_check("both", 2, 2);

    // Same-address collision reads the old contents.
    wr(4'd0, DATA_W'(8'hAA));
    wen = 1'b1; wadr = 4'd0; wdat = DATA_W'(8'hBB); ren = 1'b1; radr = 4'd0;
    step();
    idle();
    step();
    cmp("coll dut1", OUT_W'(ram1.rdat), OUT_W'(8'hAA));
    step();
    cmp("coll dut2", OUT_W'(ram2.rdat), OUT_W'(8'hAA));
    rd_check("coll after", 4'd0, DATA_W'(8'hBB), 1'b0, 1'b0);

    // Different addresses in the same cycle are independent.
    wen = 1'b1; wadr = 4'd5; wdat = DATA_W'(12'h123); ren = 1'b1; radr = 4'd3;
    step();
    idle();
    step();
    cmp("diff dut1", OUT_W'(ram1.rdat), OUT_W'(pat_a));
    step();
    cmp("diff dut2", OUT_W'(ram2.rdat), OUT_W'(pat_a));
    rd_check("diff after", 4'd5, DATA_W'(12'h123), 1'b0, 1'b0);

    // Fill all entries, then 16 back-to-back reads.
    for (int i = 0; i < DEPTH; i++) begin
      bb[i] = DATA_W'({23{4'(i)}}) ^ (DATA_W'(i + 1) << 84);
      wr(4'(i), bb[i]);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) begin
        ren = 1'b1; radr = 4'(i);
      end else begin
        ren = 1'b0;
      end
      step();
      if (i >= 1 && i <= DEPTH) cmp("b2b dut1", OUT_W'(ram1.rdat), OUT_W'(bb[i-1]));
      if (i >= 2) cmp("b2b dut2", OUT_W'(ram2.rdat), OUT_W'(bb[i-2]));
    end

    // Reset with a read in flight.
    ren = 1'b1; radr = 4'd3;
    step();
    ren = 1'b0;
    rst = 1'b1;
    step();
    cmp("rst out1", OUT_W'({ram1.rdat, ram1.rsbe, ram1.rdbe}), '0);
    cmp("rst out2", OUT_W'({ram2.rdat, ram2.rsbe, ram2.rdbe}), '0);
    cnt_check("rst", 0, 0);
    step();
    rst = 1'b0;
    step(); step();
    cmp("rst hold1", OUT_W'({ram1.rdat, ram1.rsbe, ram1.rdbe}), '0);
    cmp("rst hold2", OUT_W'({ram2.rdat, ram2.rsbe, ram2.rdbe}), '0);

    // Entries are invalid after reset even though the array holds data.
    rd_check("inv3", 4'd3, '0, 1'b0, 1'b0);
    rd_check("inv9", 4'd9, '0, 1'b0, 1'b0);
    wr(4'd9, DATA_W'(32'hDEAD_BEEF));
    rd_check("rewrite9", 4'd9, DATA_W'(32'hDEAD_BEEF), 1'b0, 1'b0);

    // SBE counter saturation.
    inj(1'b0);
    wr(4'd2, DATA_W'(8'h55));
    ren = 1'b1; radr = 4'd2;
    repeat (65540) step();
    idle();
    step(); step(); step();
    cnt_check("sat", 65535, 0);
    cmp("sat out1", OUT_W'({ram1.rdat, ram1.rsbe, ram1.rdbe}), OUT_W'({DATA_W'(8'h55), 1'b1, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
